spike_rate_counter: RTL and testbench

- Downstream readout stage for the LIF neuron tile.
- Consumes the neuron's 1-bit spike output, counts spikes over a programmable window of sampled cycles, and records first-spike latency.
- Presents the results with a one-cycle valid pulse so the tile can expose rate-coded and latency-coded outputs on uo_out or hand them to a next layer.

---
 rtl/spike_rate_counter.sv | 145 ++++++++++++++
 tb/tb_spike_rate_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_counter.sv
// spike_rate_counter: counts LIF spikes over a programmable window of sampled cycles and
// records first-spike latency; results are announced with a one-cycle count_valid pulse.
module spike_rate_counter #(
  parameter int WINDOW_BITS = 8,
  parameter int COUNT_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   spike,
  input  logic                   start,
  input  logic                   auto_restart,
  input  logic [WINDOW_BITS-1:0] window_len,
  output logic                   busy,
  output logic                   count_valid,
  output logic [COUNT_BITS-1:0]  spike_count,
  output logic [WINDOW_BITS-1:0] first_latency,
  output logic                   overflow
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [COUNT_BITS-1:0]  COUNT_MAX  = {COUNT_BITS{1'b1}};
  localparam logic [COUNT_BITS-1:0]  COUNT_ZERO = {COUNT_BITS{1'b0}};
  localparam logic [COUNT_BITS-1:0]  COUNT_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_BITS-1:0] WIN_ZERO   = {WINDOW_BITS{1'b0}};
  localparam logic [WINDOW_BITS-1:0] WIN_ONE    = {{(WINDOW_BITS-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_BITS-1:0] LAT_NONE   = {WINDOW_BITS{1'b1}};

  state_t                 state_r;
  logic [WINDOW_BITS-1:0] n_r;
  logic [WINDOW_BITS-1:0] elapsed_r;
  logic [WINDOW_BITS-1:0] lat_r;
  logic [COUNT_BITS-1:0]  count_r;
  logic                   first_seen_r;
  logic                   sat_r;
  logic                   busy_r;
  logic                   count_valid_r;
  logic [COUNT_BITS-1:0]  spike_count_r;
  logic [WINDOW_BITS-1:0] first_latency_r;
  logic                   overflow_r;

  logic [COUNT_BITS-1:0]  count_next_s;
  logic [WINDOW_BITS-1:0] lat_next_s;
  logic                   seen_next_s;
  logic                   sat_next_s;
  logic                   last_s;

  // Accumulator values after the current sample, so the window-end edge includes its own sample
  always_comb begin
    count_next_s = count_r;
    lat_next_s   = lat_r;
    seen_next_s  = first_seen_r;
    sat_next_s   = sat_r;
    last_s       = (elapsed_r == (n_r - WIN_ONE));
    if (spike) begin
      if (count_r == COUNT_MAX) begin
        sat_next_s = 1'b1;
      end else begin
        count_next_s = count_r + COUNT_ONE;
      end
      if (!first_seen_r) begin
        seen_next_s = 1'b1;
        lat_next_s  = elapsed_r;
      end else begin
        seen_next_s = first_seen_r;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Window control FSM with accumulators and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      n_r             <= WIN_ZERO;
      elapsed_r       <= WIN_ZERO;
      lat_r           <= WIN_ZERO;
      count_r         <= COUNT_ZERO;
      first_seen_r    <= 1'b0;
      sat_r           <= 1'b0;
      busy_r          <= 1'b0;
      count_valid_r   <= 1'b0;
      spike_count_r   <= COUNT_ZERO;
      first_latency_r <= LAT_NONE;
      overflow_r      <= 1'b0;
    end else begin
      count_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (window_len != WIN_ZERO)) begin
            state_r      <= RUN;
            busy_r       <= 1'b1;
            n_r          <= window_len;
            elapsed_r    <= WIN_ZERO;
            lat_r        <= WIN_ZERO;
            count_r      <= COUNT_ZERO;
            first_seen_r <= 1'b0;
            sat_r        <= 1'b0;
          end
        end
        RUN: begin
          if (ce) begin
            if (last_s) begin
              count_valid_r   <= 1'b1;
              spike_count_r   <= count_next_s;
              first_latency_r <= seen_next_s ? lat_next_s : LAT_NONE;
              overflow_r      <= sat_next_s;
              elapsed_r       <= WIN_ZERO;
              lat_r           <= WIN_ZERO;
              count_r         <= COUNT_ZERO;
              first_seen_r    <= 1'b0;
              sat_r           <= 1'b0;
              // A zero-length recapture cannot form a window, so fall back to IDLE
              if (auto_restart && (window_len != WIN_ZERO)) begin
                n_r <= window_len;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              elapsed_r    <= elapsed_r + WIN_ONE;
              count_r      <= count_next_s;
              lat_r        <= lat_next_s;
              first_seen_r <= seen_next_s;
              sat_r        <= sat_next_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign count_valid   = count_valid_r;
  assign spike_count   = spike_count_r;
  assign first_latency = first_latency_r;
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_spike_rate_counter.sv
// Self-checking bench: two instances (8-bit and 2-bit counters) share stimulus and are compared
// every cycle against a queue-based window model, plus literal checks from directed scenarios.
module tb_spike_rate_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       spike;
  logic       start;
  logic       auto_restart;
  logic [7:0] window_len;

  logic       busy8, cv8, ov8;
  logic [7:0] sc8, fl8;
  logic       busy2, cv2, ov2;
  logic [1:0] sc2;
  logic [7:0] fl2;

  spike_rate_counter #(.WINDOW_BITS(8), .COUNT_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .ce(ce), .spike(spike), .start(start),
    .auto_restart(auto_restart), .window_len(window_len), .busy(busy8),
    .count_valid(cv8), .spike_count(sc8), .first_latency(fl8), .overflow(ov8)
  );

  spike_rate_counter #(.WINDOW_BITS(8), .COUNT_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .spike(spike), .start(start),
    .auto_restart(auto_restart), .window_len(window_len), .busy(busy2),
    .count_valid(cv2), .spike_count(sc2), .first_latency(fl2), .overflow(ov2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a window is just the list of sampled spike bits
  bit m_run;
  int m_n;
  bit samples[$];
  bit m_valid;
  int m_cnt8, m_cnt2, m_lat;
  bit m_ovf8, m_ovf2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_n = 0; samples.delete(); m_valid = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0; m_lat = 255; m_ovf8 = 1'b0; m_ovf2 = 1'b0;
  endtask

  task automatic model_edge();
    int ones;
    int first;
    m_valid = 1'b0;
    if (!m_run) begin
      if (start && window_len != 8'd0) begin
        m_run = 1'b1;
        m_n = int'(window_len);
        samples.delete();
      end
    end else if (ce) begin
      samples.push_back(spike);
      if (samples.size() == m_n) begin
        ones = 0;
        first = 255;
        foreach (samples[i]) begin
          if (samples[i]) begin
            ones++;
            if (first == 255) first = i;
          end
        end
        m_cnt8 = (ones > 255) ? 255 : ones;
        m_ovf8 = (ones > 255);
        m_cnt2 = (ones > 3) ? 3 : ones;
        m_ovf2 = (ones > 3);
        m_lat = first;
        m_valid = 1'b1;
        samples.delete();
        if (auto_restart && window_len != 8'd0) m_n = int'(window_len);
        else m_run = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("busy8", int'(busy8), int'(m_run));
    chk("valid8", int'(cv8), int'(m_valid));
    chk("count8", int'(sc8), m_cnt8);
    chk("lat8", int'(fl8), m_lat);
    chk("ovf8", int'(ov8), int'(m_ovf8));
    chk("busy2", int'(busy2), int'(m_run));
    chk("valid2", int'(cv2), int'(m_valid));
    chk("count2", int'(sc2), m_cnt2);
    chk("lat2", int'(fl2), m_lat);
    chk("ovf2", int'(ov2), int'(m_ovf2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    compare();
    reset = 1'b0;
  endtask

  task automatic sample(input logic s);
    ce = 1'b1;
    spike = s;
    step();
  endtask

  task automatic begin_window(input logic [7:0] len);
    window_len = len;
    start = 1'b1;
    spike = 1'b1;
    ce = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int edges;
    reset = 1'b0; ce = 1'b1; spike = 1'b0; start = 1'b0;
    auto_restart = 1'b0; window_len = 8'd0;
    apply_reset();
    chk("rst_count", int'(sc8), 0);
    chk("rst_lat", int'(fl8), 255);
    chk("rst_busy", int'(busy8), 0);

    // Basic count: spikes on samples 2,3,5 of an 8-sample window
    begin_window(8'd8);
    for (int i = 0; i < 8; i++) sample((i == 2) || (i == 3) || (i == 5));
    chk("t1_valid", int'(cv8), 1);
    chk("t1_count", int'(sc8), 3);
    chk("t1_lat", int'(fl8), 2);
    chk("t1_ovf", int'(ov8), 0);
    sample(1'b0);
    chk("t1_busy_fall", int'(busy8), 0);
    chk("t1_single_pulse", int'(cv8), 0);

    // No spike: pulse exactly 4 sample edges after start
    begin_window(8'd4);
    edges = 0;
    do begin
      sample(1'b0);
      edges++;
    end while (!cv8 && edges < 20);
    chk("t2_edges", edges, 4);
    chk("t2_count", int'(sc8), 0);
    chk("t2_lat", int'(fl8), 255);

    // Saturation on the 2-bit instance
    begin_window(8'd6);
    for (int i = 0; i < 6; i++) sample(1'b1);
    chk("t3_count2", int'(sc2), 3);
    chk("t3_ovf2", int'(ov2), 1);
    chk("t3_lat2", int'(fl2), 0);
    chk("t3_count8", int'(sc8), 6);

    // Stall of 3 cycles with spike high and start re-pulsed while busy
    begin_window(8'd5);
    edges = 0;
    sample(1'b1); edges++;
    sample(1'b0); edges++;
    ce = 1'b0; spike = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      step();
      edges++;
    end
    start = 1'b0;
    sample(1'b0); edges++;
    sample(1'b1); edges++;
    sample(1'b0); edges++;
    chk("t4_valid", int'(cv8), 1);
    chk("t4_edges", edges, 8);
    chk("t4_count", int'(sc8), 2);
    chk("t4_lat", int'(fl8), 0);
    for (int i = 0; i < 4; i++) sample(1'b0);
    chk("t4_one_window", int'(busy8), 0);

    // Auto-restart boundary: back-to-back windows of 3
    auto_restart = 1'b1;
    begin_window(8'd3);
    sample(1'b0); sample(1'b0); sample(1'b1);
    chk("t5_valid1", int'(cv8), 1);
    chk("t5_count1", int'(sc8), 1);
    chk("t5_lat1", int'(fl8), 2);
    chk("t5_busy1", int'(busy8), 1);
    sample(1'b1);
    chk("t5_busy_mid", int'(busy8), 1);
    sample(1'b0);
    auto_restart = 1'b0;
    sample(1'b0);
    chk("t5_valid2", int'(cv8), 1);
    chk("t5_count2", int'(sc8), 1);
    chk("t5_lat2", int'(fl8), 0);
    sample(1'b0);
    chk("t5_idle", int'(busy8), 0);

    // Reset mid-window, then a zero-length start
    begin_window(8'd8);
    sample(1'b1); sample(1'b1);
    apply_reset();
    chk("t6_count", int'(sc8), 0);
    chk("t6_lat", int'(fl8), 255);
    chk("t6_busy", int'(busy8), 0);
    chk("t6_valid", int'(cv8), 0);
    begin_window(8'd0);
    for (int i = 0; i < 3; i++) sample(1'b1);
    chk("t6_zero_len", int'(busy8), 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) apply_reset();
      ce = ($urandom_range(0, 3) != 0);
      spike = ($urandom_range(0, 2) != 0);
      start = ($urandom_range(0, 4) == 0);
      auto_restart = ($urandom_range(0, 1) == 1);
      window_len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40))
                                               : 8'($urandom_range(0, 9));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
